// File: rtl/mac_signed_pkg.sv
// Shared helpers for the signed MAC pipeline: accumulator and beat-counter
// widths plus signed saturation (used when MAC_SIGNED_SATURATE_EN is defined).
package mac_signed_pkg;

  // Widest value the saturation helper handles; callers extend into it.
  localparam int SAT_W = 64;

  function automatic int acc_width(input int prec_width, input int acc_len);
    return 2 * prec_width + $clog2(acc_len) + 1;
  endfunction

  function automatic int cnt_width(input int acc_len);
    return $clog2(acc_len + 1);
  endfunction

  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] value,
    input int                      out_width
  );
    logic signed [SAT_W-1:0] max_val;
    logic signed [SAT_W-1:0] min_val;
    max_val = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    min_val = -max_val - 64'sd1;
    if (value > max_val) begin
      return max_val;
    end else if (value < min_val) begin
      return min_val;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/mac_signed_prod_stage.sv
// Stage 1 of the MAC: selects the operand MSBs, forms the signed product and
// registers it with its valid and last-of-group flags under a hold enable.
module mac_signed_prod_stage #(
  parameter int DATA_IN_WIDTH = 8,
  parameter int PREC_WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [DATA_IN_WIDTH-1:0]  data_in_1,
  input  logic [DATA_IN_WIDTH-1:0]  data_in_2,
  output logic [2*PREC_WIDTH-1:0]   prod,
  output logic                      prod_valid,
  output logic                      prod_last
);

  logic signed [PREC_WIDTH-1:0]   op_1;
  logic signed [PREC_WIDTH-1:0]   op_2;
  logic signed [2*PREC_WIDTH-1:0] product;
  logic                           unused_low;

  assign op_1    = data_in_1[DATA_IN_WIDTH-1 -: PREC_WIDTH];
  assign op_2    = data_in_2[DATA_IN_WIDTH-1 -: PREC_WIDTH];
  assign product = op_1 * op_2;

  // Low operand bits are intentionally dropped by the precision reduction.
  assign unused_low = ^{data_in_1, data_in_2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      prod_last  <= 1'b0;
    end else if (en) begin
      prod_valid <= in_valid;
      prod_last  <= in_valid & in_last;
      prod       <= in_valid ? product : prod;
    end
  end

endmodule

// File: rtl/mac_signed_pipe_param.sv
// Two-stage signed multiply-accumulate over groups of ACC_LEN beats.
// Define MAC_SIGNED_SATURATE_EN to clamp results instead of wrapping them.
module mac_signed_pipe_param
  import mac_signed_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = 8,
  parameter int PREC_WIDTH     = 4,
  parameter int DATA_OUT_WIDTH = 8,
  parameter int ACC_LEN        = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_IN_WIDTH-1:0]      data_in_1,
  input  logic [DATA_IN_WIDTH-1:0]      data_in_2,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_OUT_WIDTH-1:0]     data_out,
  output logic [cnt_width(ACC_LEN)-1:0] beat_cnt
);

  localparam int ACC_W  = acc_width(PREC_WIDTH, ACC_LEN);
  localparam int CNT_W  = cnt_width(ACC_LEN);
  localparam int PROD_W = 2 * PREC_WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACC_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                      accept;
  logic [CNT_W-1:0]          cnt_next;
  logic                      beat_last;
  logic [PROD_W-1:0]         prod;
  logic                      prod_valid;
  logic                      prod_last;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;
  logic                      group_open;
  logic [DATA_OUT_WIDTH-1:0] result;

  // A pending result the consumer has not taken freezes the whole pipe.
  assign in_ready = ~(out_valid & ~out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    cnt_next  = (beat_cnt == CNT_MAX) ? CNT_ONE : beat_cnt + CNT_ONE;
    beat_last = (cnt_next == CNT_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= cnt_next;
    end
  end

  mac_signed_prod_stage #(
    .DATA_IN_WIDTH (DATA_IN_WIDTH),
    .PREC_WIDTH    (PREC_WIDTH)
  ) u_prod_stage (
    .clk        (clk),
    .rst        (rst),
    .en         (in_ready),
    .in_valid   (in_valid),
    .in_last    (beat_last),
    .data_in_1  (data_in_1),
    .data_in_2  (data_in_2),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_last  (prod_last)
  );

  always_comb begin
    if (group_open) begin
      acc_next = acc + ACC_W'($signed(prod));
    end else begin
      acc_next = ACC_W'($signed(prod));
    end
`ifdef MAC_SIGNED_SATURATE_EN
    result = DATA_OUT_WIDTH'(saturate(SAT_W'(acc_next), DATA_OUT_WIDTH));
`else
    result = DATA_OUT_WIDTH'(acc_next);
`endif
  end

  // Stage 2: accumulate, publish the group sum on its last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      group_open <= 1'b0;
      data_out   <= '0;
      out_valid  <= 1'b0;
    end else if (in_ready) begin
      if (prod_valid) begin
        acc        <= acc_next;
        group_open <= ~prod_last;
      end
      if (prod_valid & prod_last) begin
        data_out  <= result;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_signed_pipe_param.sv
// Scoreboard bench for mac_signed_pipe_param with the default parameters;
// honours MAC_SIGNED_SATURATE_EN in its reference model.
module tb_mac_signed_pipe_param;

  localparam int AL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d1;
  logic [7:0] d2;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;
  logic [2:0] beat_cnt;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];
  int model_sum = 0;
  int model_cnt = 0;
  int stall_left = 0;
  bit rand_ready = 1'b0;
  bit b2b = 1'b0;
  bit b2b_seen = 1'b0;
  int cycle = 0;
  int last_out_cycle = 0;
  int results = 0;
  bit was_stalled = 1'b0;
  logic [7:0] held;

  always #5 clk = ~clk;

  mac_signed_pipe_param dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in_1 (d1),
    .data_in_2 (d2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .beat_cnt  (beat_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Top 4 bits of a signed byte are its value divided by 16, rounded down.
  function automatic int top_val(input logic [7:0] v);
    return int'($signed(v)) >>> 4;
  endfunction

  function automatic logic [7:0] expect_out(input int sum);
    logic [31:0] s;
    s = sum;
`ifdef MAC_SIGNED_SATURATE_EN
    if (sum > 127) return 8'h7F;
    if (sum < -128) return 8'h80;
`endif
    return s[7:0];
  endfunction

  task automatic model_accept(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = top_val(a) * top_val(b);
    if (model_cnt == 0 || model_cnt == AL) model_sum = p;
    else model_sum = model_sum + p;
    model_cnt = (model_cnt == AL) ? 1 : model_cnt + 1;
    if (model_cnt == AL) exp_q.push_back(expect_out(model_sum));
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, output int tries);
    logic ok;
    in_valid = 1'b1;
    d1 = a;
    d2 = b;
    tries = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!ok && tries < 200);
    if (!ok) begin
      check("accept_timeout", 0, 1);
    end else begin
      model_accept(a, b);
      check("beat_cnt", beat_cnt, model_cnt);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  always @(posedge clk) cycle++;

  // Consumer: optional scripted stall after a result, otherwise random or always ready.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stall behaviour.
  always @(negedge clk) begin
    if (rst) begin
      was_stalled = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        check("in_ready_low_stall", in_ready, 0);
        if (was_stalled) check("data_out_hold", data_out, held);
        held = data_out;
        was_stalled = 1'b1;
      end else begin
        was_stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        check("result_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("data_out", data_out, exp_q.pop_front());
        results++;
        if (b2b && b2b_seen) check("b2b_spacing", cycle - last_out_cycle, AL);
        last_out_cycle = cycle;
        b2b_seen = b2b;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int r0;
    rst = 1'b1;
    in_valid = 1'b0;
    d1 = 8'h00;
    d2 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    // 3x2 four times, latency: result visible after the edge following the accept edge
    repeat (4) send_beat(8'h30, 8'h20, t);
    in_valid = 1'b0;
    check("latency_early", out_valid, 0);
    @(posedge clk);
    #1;
    check("latency_valid", out_valid, 1);
    check("latency_data", data_out, 24);
    @(posedge clk);
    #1;
    check("single_pulse", out_valid, 0);

    repeat (4) send_beat(8'h70, 8'h70, t);
    idle(3);
    send_beat(8'h80, 8'h70, t);
    send_beat(8'h80, 8'h80, t);
    send_beat(8'h10, 8'hF0, t);
    send_beat(8'h00, 8'h50, t);
    drain();

    // Consumer stalls 5 cycles while the next group is already arriving
    stall_left = 5;
    repeat (4) send_beat(8'h30, 8'h20, t);
    for (int i = 0; i < 4; i++) send_beat(8'($urandom), 8'($urandom), t);
    drain();

    // Reset mid-group discards the partial sum
    send_beat(8'h70, 8'h70, t);
    send_beat(8'h70, 8'h70, t);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_data_out", data_out, 0);
    check("mid_rst_beat_cnt", beat_cnt, 0);
    in_valid = 1'b0;
    model_cnt = 0;
    model_sum = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    repeat (4) send_beat(8'h30, 8'hE0, t);
    drain();

    // Back-to-back groups, in_valid held high
    r0 = results;
    b2b = 1'b1;
    b2b_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      send_beat(8'($urandom), 8'($urandom), t);
      check("b2b_no_stall", t, 1);
    end
    drain();
    b2b = 1'b0;
    check("b2b_result_count", results - r0, 3);

    // Random operands, gaps and backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      send_beat(8'($urandom), 8'($urandom), t);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    rand_ready = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mac_signed_pipe_param.md
MAC_SIGNED_PIPE_PARAM -- requirements
Module: mac_signed_pipe_param

Interface
REQ-001 The block SHALL expose parameter DATA_IN_WIDTH, default 8: operand bus width.
REQ-002 The block SHALL expose parameter PREC_WIDTH, default 4: operand MSBs used for multiplication; must be 2 to DATA_IN_WIDTH.
REQ-003 The block SHALL expose parameter DATA_OUT_WIDTH, default 8: result width.
REQ-004 The block SHALL expose parameter ACC_LEN, default 4: products summed per result; must be at least 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: operand beat valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts a beat.
REQ-009 The block SHALL have ports data_in_1 and data_in_2, inputs, DATA_IN_WIDTH bits each: signed operands.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 The block SHALL have port data_out, output, DATA_OUT_WIDTH bits: signed accumulated result.
REQ-013 The block SHALL have port beat_cnt, output, clog2(ACC_LEN+1) bits: beats accepted in the current group.

Function
REQ-014 A beat SHALL be accepted when in_valid and in_ready are both high on a rising clk edge.
REQ-015 in_ready SHALL equal NOT(out_valid AND NOT out_ready), combinationally; when it is low, all pipeline registers hold.
REQ-016 Stage 1 SHALL register the signed product of the top PREC_WIDTH bits of each operand (width 2*PREC_WIDTH), a valid bit, and a last-of-group flag.
REQ-017 Stage 2 SHALL accumulate into a signed register of width 2*PREC_WIDTH+clog2(ACC_LEN)+1 with no internal overflow; the first beat of a group loads the product, and later beats add to it.
REQ-018 On the last beat of a group (beat_cnt reaches ACC_LEN), stage 2 SHALL load data_out and set out_valid; the next beat starts a fresh group with no bubble.
REQ-019 Latency SHALL be 2 cycles: out_valid rises on the second rising edge after the last beat is accepted.
REQ-020 out_valid and data_out SHALL hold until out_valid AND out_ready; then out_valid clears unless a new result loads on the same edge.
REQ-021 beat_cnt SHALL wrap from ACC_LEN to 1 when the first beat of the next group is accepted.
REQ-022 When ACC_LEN is 1, every beat SHALL produce one result.
REQ-023 If DATA_OUT_WIDTH is at least the accumulator width, data_out SHALL be the sign-extended accumulator.

Reset
REQ-024 On assertion of rst, asynchronously: out_valid=0, data_out=0, beat_cnt=0, accumulator=0, stage-1 valid=0; a partial group is discarded.
REQ-025 After rst deasserts, in_ready SHALL be 1 and the first accepted beat starts group 1.

Configuration
REQ-026 With MAC_SIGNED_SATURATE_EN defined, an accumulator outside the DATA_OUT_WIDTH signed range SHALL clamp to the signed maximum or minimum.
REQ-027 Without MAC_SIGNED_SATURATE_EN, data_out SHALL be the low DATA_OUT_WIDTH accumulator bits (two's-complement wrap).

Structure
REQ-028 A shared package mac_signed_pkg SHALL hold the accumulator-width function, the beat-counter-width function, and the saturation function.
REQ-029 The stage-1 multiply SHALL be a sub-module, mac_signed_prod_stage, containing the MSB selection, signed product, and registers with hold enable.

Verification (DATA_IN_WIDTH=8, PREC_WIDTH=4, DATA_OUT_WIDTH=8, ACC_LEN=4)
REQ-030 Four beats of 8'h30 x 8'h20 (3x2), out_ready=1 -> out_valid pulses once, 2 cycles after the 4th beat; data_out=24.
REQ-031 Four beats of 8'h70 x 8'h70 (7x7=49, sum 196) -> data_out=127 with the macro, 8'hC4 (-60) without.
REQ-032 Beats of 8'h80 x 8'h70 (-8x7), 8'h80 x 8'h80 (64), 8'h10 x 8'hF0 (-1), 8'h00 x 8'h50 (0) -> data_out=7.
REQ-033 out_ready=0 for 5 cycles after a result -> in_ready low, data_out stable, the following group is not corrupted, the next result is correct.
REQ-034 rst asserted after 2 beats of a group -> all outputs 0 immediately; the next 4 beats yield only their own sum.
REQ-035 Back-to-back groups with in_valid held high and out_ready=1 -> one result every 4 cycles, no lost beats.
